// File: rtl/cache_arb_pkg.sv
// Shared types and helpers for the cache bus arbiter.
// Source IDs identify which requester issued a read so the returning data
// can be routed back; bus_cmd_t bundles one Avalon-MM command.
package cache_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef logic src_id_t;

  localparam src_id_t SRC_S0 = 1'b0;
  localparam src_id_t SRC_S1 = 1'b1;

  typedef struct packed {
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byte_enable;
    logic [DATA_W-1:0] write_data;
  } bus_cmd_t;

  // Ceiling log2, used to size FIFO pointers and the occupancy counter.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cache_arb_id_fifo.sv
// In-order FIFO of 1-bit source IDs for reads outstanding on the master bus.
// A pop on an empty FIFO is ignored; a push on a full FIFO is accepted only
// when a pop frees a slot in the same cycle.
module cache_arb_id_fifo
  import cache_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rest,
  input  logic    push,
  input  src_id_t push_id,
  input  logic    pop,
  output src_id_t head,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
  localparam int CNT_W = clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  src_id_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             pop_en;
  logic             push_en;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_id;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop_en) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push_en && !pop_en) begin
        count <= count + CNT_W'(1);
      end else if (!push_en && pop_en) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Two-to-one Avalon-MM arbiter sharing the cache master bus m0 between the
// instruction side (s0) and data side (s1). Commands pass combinationally
// through the grant mux; a stalled grant is locked until accepted; read
// source IDs are queued so returning data is steered to the issuing port.
// Build option: define CACHE_ARB_RR_EN for round-robin tie breaking,
// otherwise s0 wins every tie.
module cache_bus_arbiter
  import cache_arb_pkg::*;
#(
  parameter int MAX_PENDING = 4
) (
  input  logic              clk,
  input  logic              rest,
  input  logic [ADDR_W-1:0] s0_address,
  input  logic [BE_W-1:0]   s0_byteEnable,
  input  logic              s0_read,
  input  logic              s0_write,
  input  logic [DATA_W-1:0] s0_writeData,
  output logic [DATA_W-1:0] s0_readData,
  output logic              s0_waitRequest,
  output logic              s0_readDataValid,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic [BE_W-1:0]   s1_byteEnable,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [DATA_W-1:0] s1_writeData,
  output logic [DATA_W-1:0] s1_readData,
  output logic              s1_waitRequest,
  output logic              s1_readDataValid,
  output logic [ADDR_W-1:0] m0_address,
  output logic [BE_W-1:0]   m0_byteEnable,
  output logic              m0_read,
  output logic              m0_write,
  output logic [DATA_W-1:0] m0_writeData,
  input  logic              m0_waitRequest,
  input  logic              m0_readDataValid,
  input  logic [DATA_W-1:0] m0_readData
);

  bus_cmd_t cmd_s0;
  bus_cmd_t cmd_s1;
  bus_cmd_t cmd_sel;

  logic    fifo_full;
  logic    fifo_empty;
  src_id_t fifo_head;
  logic    pop_fire;
  logic    push_fire;
  logic    read_ok;

  logic    req_s0;
  logic    req_s1;
  logic    elig_s0;
  logic    elig_s1;

  logic    lock_valid;
  src_id_t lock_id;
  src_id_t tie_winner;
  logic    gnt_valid;
  src_id_t gnt_id;
  logic    cmd_active;

  assign cmd_s0 = '{read: s0_read, write: s0_write, address: s0_address,
                    byte_enable: s0_byteEnable, write_data: s0_writeData};
  assign cmd_s1 = '{read: s1_read, write: s1_write, address: s1_address,
                    byte_enable: s1_byteEnable, write_data: s1_writeData};

  // A returning beat pops only if something is outstanding; an unexpected
  // beat is dropped without touching the count.
  assign pop_fire = m0_readDataValid & ~fifo_empty;

  // Reads may go out when there is room, counting a slot freed this cycle.
  assign read_ok = ~fifo_full | pop_fire;

  assign req_s0  = s0_read | s0_write;
  assign req_s1  = s1_read | s1_write;
  assign elig_s0 = s0_write | (s0_read & read_ok);
  assign elig_s1 = s1_write | (s1_read & read_ok);

`ifdef CACHE_ARB_RR_EN
  src_id_t rr_pref;
  logic    cmd_accept;

  assign cmd_accept = cmd_active & ~m0_waitRequest;
  assign tie_winner = rr_pref;

  // Hand preference to the other port once the preferred port gets a command through.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      rr_pref <= SRC_S0;
    end else if (cmd_accept && (gnt_id == rr_pref)) begin
      rr_pref <= ~rr_pref;
    end
  end
`else
  assign tie_winner = SRC_S0;
`endif

  // Grant selection: a locked grant sticks, otherwise single requester wins
  // and ties go to the preferred port; nothing is granted during reset.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = SRC_S0;
    if (lock_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = lock_id;
    end else if (elig_s0 && elig_s1) begin
      gnt_valid = 1'b1;
      gnt_id    = tie_winner;
    end else if (elig_s0) begin
      gnt_valid = 1'b1;
      gnt_id    = SRC_S0;
    end else if (elig_s1) begin
      gnt_valid = 1'b1;
      gnt_id    = SRC_S1;
    end
    if (!rest) begin
      gnt_valid = 1'b0;
    end
  end

  // Command mux from the granted port onto m0; idle bus drives zeros.
  always_comb begin
    cmd_sel = '0;
    if (gnt_valid) begin
      cmd_sel = (gnt_id == SRC_S1) ? cmd_s1 : cmd_s0;
    end
  end

  assign m0_read       = cmd_sel.read & read_ok;
  assign m0_write      = cmd_sel.write;
  assign m0_address    = cmd_sel.address;
  assign m0_byteEnable = cmd_sel.byte_enable;
  assign m0_writeData  = cmd_sel.write_data;

  assign cmd_active = m0_read | m0_write;
  assign push_fire  = m0_read & ~m0_waitRequest;

  // The granted port sees the downstream stall; a losing requester is held
  // off; an idle port sees no wait. Reset holds both ports off.
  always_comb begin
    s0_waitRequest = 1'b1;
    s1_waitRequest = 1'b1;
    if (rest) begin
      s0_waitRequest = (gnt_valid && gnt_id == SRC_S0) ? m0_waitRequest : req_s0;
      s1_waitRequest = (gnt_valid && gnt_id == SRC_S1) ? m0_waitRequest : req_s1;
    end
  end

  assign s0_readDataValid = rest & pop_fire & (fifo_head == SRC_S0);
  assign s1_readDataValid = rest & pop_fire & (fifo_head == SRC_S1);
  assign s0_readData      = rest ? m0_readData : '0;
  assign s1_readData      = rest ? m0_readData : '0;

  // Lock follows a stalled command and drops on the cycle it is accepted.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      lock_valid <= 1'b0;
      lock_id    <= SRC_S0;
    end else begin
      lock_valid <= cmd_active & m0_waitRequest;
      if (cmd_active && m0_waitRequest) begin
        lock_id <= gnt_id;
      end
    end
  end

  cache_arb_id_fifo #(
    .DEPTH (MAX_PENDING)
  ) u_id_fifo (
    .clk     (clk),
    .rest    (rest),
    .push    (push_fire),
    .push_id (gnt_id),
    .pop     (m0_readDataValid),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: directed vector table, hand
// sequences for tie breaking and reset, then random traffic against a
// queue-based reference model.
module tb_cache_bus_arbiter;

  localparam int MAXP = 4;
`ifdef CACHE_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk;
  logic        rest;
  logic        cmd_rd [2];
  logic        cmd_wr [2];
  logic [31:0] cmd_addr [2];
  logic [3:0]  cmd_be [2];
  logic [31:0] cmd_wd [2];
  logic        m0_wait;
  logic        m0_rdv;
  logic [31:0] m0_rdata;

  logic [31:0] s0_readData, s1_readData;
  logic        s0_waitRequest, s1_waitRequest;
  logic        s0_readDataValid, s1_readDataValid;
  logic [31:0] m0_address, m0_writeData;
  logic [3:0]  m0_byteEnable;
  logic        m0_read, m0_write;

  int n_checks = 0;
  int n_fail   = 0;

  cache_bus_arbiter #(.MAX_PENDING(MAXP)) dut (
    .clk              (clk),
    .rest             (rest),
    .s0_address       (cmd_addr[0]),
    .s0_byteEnable    (cmd_be[0]),
    .s0_read          (cmd_rd[0]),
    .s0_write         (cmd_wr[0]),
    .s0_writeData     (cmd_wd[0]),
    .s0_readData      (s0_readData),
    .s0_waitRequest   (s0_waitRequest),
    .s0_readDataValid (s0_readDataValid),
    .s1_address       (cmd_addr[1]),
    .s1_byteEnable    (cmd_be[1]),
    .s1_read          (cmd_rd[1]),
    .s1_write         (cmd_wr[1]),
    .s1_writeData     (cmd_wd[1]),
    .s1_readData      (s1_readData),
    .s1_waitRequest   (s1_waitRequest),
    .s1_readDataValid (s1_readDataValid),
    .m0_address       (m0_address),
    .m0_byteEnable    (m0_byteEnable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writeData     (m0_writeData),
    .m0_waitRequest   (m0_wait),
    .m0_readDataValid (m0_rdv),
    .m0_readData      (m0_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < 2; p++) begin
      cmd_rd[p] = 1'b0;
      cmd_wr[p] = 1'b0;
      cmd_addr[p] = '0;
    end
    cmd_be[0] = 4'h3;
    cmd_be[1] = 4'hC;
    cmd_wd[0] = 32'h0A0A0A0A;
    cmd_wd[1] = 32'h0B0B0B0B;
    m0_wait  = 1'b0;
    m0_rdv   = 1'b0;
    m0_rdata = '0;
  endtask

  // Ends on a falling edge with reset released.
  task automatic do_reset();
    idle_inputs();
    rest = 1'b0;
    repeat (2) @(negedge clk);
    rest = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic r0, w0; logic [31:0] a0;
    logic r1, w1; logic [31:0] a1;
    logic mw, mv; logic [31:0] md;
    logic e_mr, e_mw; logic [31:0] e_ma;
    logic e_w0, e_w1, e_v0, e_v1;
  } vec_t;

  function automatic vec_t mk(input logic r0, w0, input logic [31:0] a0,
                              input logic r1, w1, input logic [31:0] a1,
                              input logic mw, mv, input logic [31:0] md,
                              input logic emr, emw, input logic [31:0] ema,
                              input logic ew0, ew1, ev0, ev1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.r1 = r1; v.w1 = w1; v.a1 = a1;
    v.mw = mw; v.mv = mv; v.md = md; v.e_mr = emr; v.e_mw = emw; v.e_ma = ema;
    v.e_w0 = ew0; v.e_w1 = ew1; v.e_v0 = ev0; v.e_v1 = ev1;
    return v;
  endfunction

  localparam int NV = 21;
  vec_t tbl [NV];

  // ---------------- reference model ----------------
  int q[$];
  int lock_owner;
  int pref;
  int e_g;
  bit e_pop, e_mr, e_mw;
  bit e_w [2];
  bit e_v [2];

  task automatic model_reset();
    q.delete();
    lock_owner = -1;
    pref = 0;
  endtask

  task automatic model_eval();
    bit full, can_read;
    bit want [2];
    bit elig [2];
    full     = (q.size() >= MAXP);
    e_pop    = m0_rdv && (q.size() > 0);
    can_read = !full || e_pop;
    for (int p = 0; p < 2; p++) begin
      want[p] = cmd_rd[p] || cmd_wr[p];
      elig[p] = cmd_wr[p] || (cmd_rd[p] && can_read);
    end
    if (lock_owner >= 0) e_g = lock_owner;
    else if (elig[0] && elig[1]) e_g = RR_EN ? pref : 0;
    else if (elig[0]) e_g = 0;
    else if (elig[1]) e_g = 1;
    else e_g = -1;
    e_mr = 1'b0;
    e_mw = 1'b0;
    if (e_g >= 0) begin
      e_mr = cmd_rd[e_g] && can_read;
      e_mw = cmd_wr[e_g];
    end
    for (int p = 0; p < 2; p++) begin
      e_w[p] = (e_g == p) ? m0_wait : want[p];
      e_v[p] = e_pop && (q[0] == p);
    end
  endtask

  task automatic model_step();
    bit cmd;
    if (e_pop) void'(q.pop_front());
    if (e_mr && !m0_wait) q.push_back(e_g);
    cmd = e_mr || e_mw;
    lock_owner = (cmd && m0_wait) ? e_g : -1;
    if (RR_EN && cmd && !m0_wait && e_g == pref) pref = 1 - pref;
  endtask

  initial begin
    int prev_port;
    int exp_port;
    bit hold [2];
    int sel;

    tbl[0]  = mk(1,0,32'h100, 0,0,0, 0,0,0,            1,0,32'h100, 0,0,0,0);
    tbl[1]  = mk(0,0,0,       0,0,0, 0,0,0,            0,0,0,       0,0,0,0);
    tbl[2]  = mk(0,0,0,       0,0,0, 0,1,32'hDEADBEEF, 0,0,0,       0,0,1,0);
    tbl[3]  = mk(0,0,0,       0,1,32'h200, 1,0,0,      0,1,32'h200, 0,1,0,0);
    tbl[4]  = mk(1,0,32'h104, 0,1,32'h200, 1,0,0,      0,1,32'h200, 1,1,0,0);
    tbl[5]  = mk(1,0,32'h104, 0,1,32'h200, 1,0,0,      0,1,32'h200, 1,1,0,0);
    tbl[6]  = mk(1,0,32'h104, 0,1,32'h200, 0,0,0,      0,1,32'h200, 1,0,0,0);
    tbl[7]  = mk(1,0,32'h104, 0,0,0, 0,0,0,            1,0,32'h104, 0,0,0,0);
    tbl[8]  = mk(0,0,0,       0,0,0, 0,1,32'h11111111, 0,0,0,       0,0,1,0);
    tbl[9]  = mk(1,0,32'h300, 0,0,0, 0,0,0,            1,0,32'h300, 0,0,0,0);
    tbl[10] = mk(0,0,0,       1,0,32'h304, 0,0,0,      1,0,32'h304, 0,0,0,0);
    tbl[11] = mk(0,0,0,       1,0,32'h308, 0,0,0,      1,0,32'h308, 0,0,0,0);
    tbl[12] = mk(1,0,32'h30C, 0,0,0, 0,0,0,            1,0,32'h30C, 0,0,0,0);
    tbl[13] = mk(1,0,32'h310, 0,0,0, 0,0,0,            0,0,0,       1,0,0,0);
    tbl[14] = mk(1,0,32'h310, 0,1,32'h400, 0,0,0,      0,1,32'h400, 1,0,0,0);
    tbl[15] = mk(1,0,32'h310, 0,0,0, 0,1,32'hAAAA0001, 1,0,32'h310, 0,0,1,0);
    tbl[16] = mk(0,0,0,       0,0,0, 0,1,32'hAAAA0002, 0,0,0,       0,0,0,1);
    tbl[17] = mk(0,0,0,       0,0,0, 0,1,32'hAAAA0003, 0,0,0,       0,0,0,1);
    tbl[18] = mk(0,0,0,       0,0,0, 0,1,32'hAAAA0004, 0,0,0,       0,0,1,0);
    tbl[19] = mk(0,0,0,       0,0,0, 0,1,32'hAAAA0005, 0,0,0,       0,0,1,0);
    tbl[20] = mk(0,0,0,       0,0,0, 0,1,32'hAAAA0006, 0,0,0,       0,0,0,0);

    idle_inputs();
    rest = 1'b0;
    #2;
    chk("reset m0_read", m0_read, 0);
    chk("reset m0_write", m0_write, 0);
    chk("reset s0_wait", s0_waitRequest, 1);
    chk("reset s1_wait", s1_waitRequest, 1);
    chk("reset s0_rdv", s0_readDataValid, 0);
    chk("reset s1_rdv", s1_readDataValid, 0);
    do_reset();

    // Directed table, one vector per cycle.
    for (int k = 0; k < NV; k++) begin
      cmd_rd[0] = tbl[k].r0; cmd_wr[0] = tbl[k].w0; cmd_addr[0] = tbl[k].a0;
      cmd_rd[1] = tbl[k].r1; cmd_wr[1] = tbl[k].w1; cmd_addr[1] = tbl[k].a1;
      m0_wait = tbl[k].mw; m0_rdv = tbl[k].mv; m0_rdata = tbl[k].md;
      #1;
      chk($sformatf("v%0d m0_read", k), m0_read, tbl[k].e_mr);
      chk($sformatf("v%0d m0_write", k), m0_write, tbl[k].e_mw);
      if (tbl[k].e_mr || tbl[k].e_mw)
        chk($sformatf("v%0d m0_address", k), m0_address, tbl[k].e_ma);
      chk($sformatf("v%0d s0_wait", k), s0_waitRequest, tbl[k].e_w0);
      chk($sformatf("v%0d s1_wait", k), s1_waitRequest, tbl[k].e_w1);
      chk($sformatf("v%0d s0_rdv", k), s0_readDataValid, tbl[k].e_v0);
      chk($sformatf("v%0d s1_rdv", k), s1_readDataValid, tbl[k].e_v1);
      chk($sformatf("v%0d s0_rdata", k), s0_readData, tbl[k].md);
      chk($sformatf("v%0d s1_rdata", k), s1_readData, tbl[k].md);
      @(negedge clk);
    end

    // Both ports reading every cycle; one return per cycle keeps the FIFO from filling.
    do_reset();
    prev_port = 0;
    for (int k = 0; k < 6; k++) begin
      cmd_rd[0] = 1'b1; cmd_addr[0] = 32'h500;
      cmd_rd[1] = 1'b1; cmd_addr[1] = 32'h600;
      m0_wait = 1'b0; m0_rdv = (k > 0); m0_rdata = 32'(k);
      exp_port = RR_EN ? (k % 2) : 0;
      #1;
      chk($sformatf("tie%0d m0_read", k), m0_read, 1);
      chk($sformatf("tie%0d m0_address", k), m0_address, (exp_port == 1) ? 32'h600 : 32'h500);
      chk($sformatf("tie%0d s0_wait", k), s0_waitRequest, exp_port != 0);
      chk($sformatf("tie%0d s1_wait", k), s1_waitRequest, exp_port != 1);
      chk($sformatf("tie%0d s0_rdv", k), s0_readDataValid, (k > 0) && (prev_port == 0));
      chk($sformatf("tie%0d s1_rdv", k), s1_readDataValid, (k > 0) && (prev_port == 1));
      prev_port = exp_port;
      @(negedge clk);
    end

    // Reset in the middle of traffic with two reads outstanding.
    do_reset();
    cmd_rd[0] = 1'b1; cmd_addr[0] = 32'h700;
    @(negedge clk);
    cmd_rd[0] = 1'b0;
    cmd_rd[1] = 1'b1; cmd_addr[1] = 32'h704;
    @(negedge clk);
    cmd_rd[1] = 1'b0;
    cmd_rd[0] = 1'b1; cmd_addr[0] = 32'h708;
    m0_rdv = 1'b1; m0_rdata = 32'h12345678;
    #1;
    chk("prerst s0_rdv", s0_readDataValid, 1);
    chk("prerst m0_read", m0_read, 1);
    rest = 1'b0;
    #1;
    chk("midrst m0_read", m0_read, 0);
    chk("midrst m0_write", m0_write, 0);
    chk("midrst m0_address", m0_address, 0);
    chk("midrst s0_wait", s0_waitRequest, 1);
    chk("midrst s1_wait", s1_waitRequest, 1);
    chk("midrst s0_rdv", s0_readDataValid, 0);
    chk("midrst s1_rdv", s1_readDataValid, 0);
    chk("midrst s0_rdata", s0_readData, 0);
    @(negedge clk);
    @(negedge clk);
    idle_inputs();
    rest = 1'b1;
    m0_rdv = 1'b1; m0_rdata = 32'hCAFEF00D;
    #1;
    chk("postrst s0_rdv", s0_readDataValid, 0);
    chk("postrst s1_rdv", s1_readDataValid, 0);
    @(negedge clk);

    // Random traffic; commands stay stable while their port is held off.
    do_reset();
    model_reset();
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!hold[p]) begin
          sel = $urandom_range(0, 4);
          cmd_rd[p]   = (sel == 1) || (sel == 2);
          cmd_wr[p]   = (sel == 3);
          cmd_addr[p] = $urandom;
          cmd_be[p]   = 4'($urandom);
          cmd_wd[p]   = $urandom;
        end
      end
      m0_wait  = ($urandom_range(0, 3) == 0);
      m0_rdv   = ($urandom_range(0, 2) == 0);
      m0_rdata = $urandom;
      #1;
      model_eval();
      chk("rnd m0_read", m0_read, e_mr);
      chk("rnd m0_write", m0_write, e_mw);
      if (e_g >= 0) begin
        chk("rnd m0_address", m0_address, cmd_addr[e_g]);
        chk("rnd m0_be", 32'(m0_byteEnable), 32'(cmd_be[e_g]));
        chk("rnd m0_wdata", m0_writeData, cmd_wd[e_g]);
      end
      chk("rnd s0_wait", s0_waitRequest, e_w[0]);
      chk("rnd s1_wait", s1_waitRequest, e_w[1]);
      chk("rnd s0_rdv", s0_readDataValid, e_v[0]);
      chk("rnd s1_rdv", s1_readDataValid, e_v[1]);
      chk("rnd s0_rdata", s0_readData, m0_rdata);
      for (int p = 0; p < 2; p++) begin
        hold[p] = (cmd_rd[p] || cmd_wr[p]) && e_w[p];
      end
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_bus_arbiter.md
# cache_bus_arbiter

Two-to-one Avalon-MM-style arbiter that shares the cache's single downstream master bus between the instruction-side (s0) and data-side (s1) requesters. Commands are forwarded combinationally from the granted port to m0. The grant is locked while m0 stalls. Outstanding read source IDs are tracked in order, so read data returns to the port that issued the read.

## Interface
Parameters:
- MAX_PENDING, 4, maximum outstanding reads on m0; power of two, 1..16

Ports:
- clk  in  1  clock; all state updates on rising edge
- rest  in  1  asynchronous, active-low reset
- s0_address / s1_address  in  32  requester byte address
- s0_byteEnable / s1_byteEnable  in  4  byte lanes
- s0_read / s1_read  in  1  read request
- s0_write / s1_write  in  1  write request
- s0_writeData / s1_writeData  in  32  write data
- s0_readData / s1_readData  out  32  both driven from m0_readData
- s0_waitRequest / s1_waitRequest  out  1  command not accepted this cycle
- s0_readDataValid / s1_readDataValid  out  1  read data for this port
- m0_address  out  32  forwarded address
- m0_byteEnable  out  4  forwarded byte lanes
- m0_read / m0_write  out  1  forwarded command
- m0_writeData  out  32  forwarded write data
- m0_waitRequest  in  1  downstream stall
- m0_readDataValid  in  1  downstream read data valid
- m0_readData  in  32  downstream read data

## Operation
- A port requests when its read or write is high. Read and write both high on one port is illegal; the command is forwarded unchanged.
- Grant selection when unlocked:
  - Only one port requesting: that port wins.
  - Both requesting: winner per Configuration.
  - No port requesting: no grant; m0_read = m0_write = 0.
- Granted port:
  - Its address, byteEnable, writeData, read and write drive m0 in the same cycle.
  - Its waitRequest = m0_waitRequest.
- Non-granted requesting port: waitRequest = 1. Idle ports: waitRequest = 0.
- Lock:
  - If the granted command sees m0_waitRequest = 1, lock_valid is set and lock_id = the granted port.
  - While locked, the grant is forced to lock_id.
  - Lock clears on the cycle the command is accepted (m0_waitRequest = 0).
- Pending-read FIFO (depth MAX_PENDING, entries 1 bit = source ID):
  - Push the granted ID on read acceptance (m0_read & !m0_waitRequest).
  - Pop on m0_readDataValid.
  - Head selects which s*_readDataValid pulses; the other stays 0.
- FIFO full: reads from either port are not forwarded. The requesting port sees waitRequest = 1 and m0_read = 0. Writes still arbitrate and forward normally.
- m0_readDataValid with the FIFO empty is a protocol error: both readDataValid outputs stay 0 and the count does not underflow.

## Timing
- Command path s→m0: 0 cycles, combinational through the grant mux.
- Read-data path m0→s: 0 cycles; readDataValid is decoded from the FIFO head in the same cycle.
- Push and pop in the same cycle: count unchanged. This holds even when full, because the pop frees the slot before the push is checked.
- While rest = 0, and on reset (async assert, sync release):
  - FIFO count = 0, lock_valid = 0, rr pointer = s0-preferred.
  - m0_read = m0_write = 0; s0/s1_waitRequest = 1; s0/s1_readDataValid = 0.
  - Data outputs are don't-care, driven 0.
- Reset asserted mid-transfer: pending reads are discarded. Later m0_readDataValid pulses are handled as empty-FIFO errors.

## Configuration
- CACHE_ARB_RR_EN defined:
  - Round-robin between s0 and s1. A 1-bit rr pointer flips to prefer the other port after each accepted command from the preferred port.
  - Ties go to the pointer's preferred port.
- Not defined: fixed priority, s0 always wins a tie; no rr register is built.

## Structure
- Package cache_arb_pkg holds:
  - Source ID constants: SRC_S0 = 1'b0, SRC_S1 = 1'b1.
  - Typedef src_id_t.
  - Function clog2 for sizing the FIFO pointers.
- Sub-module cache_arb_id_fifo: synchronous 1-bit-wide FIFO with push, pop, head, full and empty outputs, and the same clk/rest. The top level holds the grant, lock and rr logic.

## Test plan
- s0 read at 0x100, s1 idle, m0_waitRequest = 0 → m0_read = 1 and m0_address = 0x100 in the same cycle. Two cycles later, m0_readDataValid with 0xDEADBEEF → s0_readDataValid = 1, s0_readData = 0xDEADBEEF, s1_readDataValid = 0.
- Both ports issue reads continuously with CACHE_ARB_RR_EN → grants alternate s0, s1, s0, s1. Without the macro → s0 granted every cycle and s1_waitRequest stays 1.
- s1 write is granted and m0_waitRequest is held 3 cycles while s0 starts requesting → m0 holds the s1 command all 3 cycles. s0 is granted on the cycle after acceptance.
- MAX_PENDING = 4: four s0 reads accepted with no returns → 5th read held (s0_waitRequest = 1, m0_read = 0). An s1 write in that window is still forwarded. One m0_readDataValid → the 5th read is accepted in that same cycle.
- Reads in order s0, s1, s1, s0 → return pulses route s0, s1, s1, s0. An extra m0_readDataValid after the FIFO empties → no valid pulse on either port.
- rest asserted with 2 reads pending → all outputs at their reset values immediately. After release, the FIFO count is 0.
